// File: rtl/ir_key_event_decoder_if.sv
// Key event decoder port bundle: frame input, table
// write port, event handshake and status pulses.
interface ir_key_event_decoder_if #(
   parameter int SIGNAL_WIDTH = 32,
   parameter int KEY_WIDTH    = 4
);
   logic [SIGNAL_WIDTH-1:0] i_code;
   logic                    i_code_valid;
   logic                    i_repeat;
   logic                    i_tbl_we;
   logic [KEY_WIDTH-1:0]    i_tbl_addr;
   logic [SIGNAL_WIDTH-1:0] i_tbl_code;
   logic [KEY_WIDTH-1:0]    o_key;
   logic                    o_key_repeat;
   logic                    o_key_valid;
   logic                    i_key_ready;
   logic                    o_held;
   logic                    o_unknown;
   logic                    o_overrun;

   modport slave (
      input  i_code, i_code_valid, i_repeat,
      input  i_tbl_we, i_tbl_addr, i_tbl_code,
      input  i_key_ready,
      output o_key, o_key_repeat, o_key_valid,
      output o_held, o_unknown, o_overrun
   );

   modport master (
      output i_code, i_code_valid, i_repeat,
      output i_tbl_we, i_tbl_addr, i_tbl_code,
      output i_key_ready,
      input  o_key, o_key_repeat, o_key_valid,
      input  o_held, o_unknown, o_overrun
   );
endinterface

// File: rtl/ir_key_event_decoder.sv
// IR key event decoder: sequential search of a programmable
// code table, press/auto-repeat events and hold tracking.
module ir_key_event_decoder #(
   parameter int SIGNAL_WIDTH   = 32,
   parameter int NUM_KEYS       = 16,
   parameter int KEY_WIDTH      = $clog2(NUM_KEYS),
   parameter int REPEAT_TIMEOUT = 6_000_000
) (
   input logic i_clk,
   input logic i_reset,
   ir_key_event_decoder_if.slave bus
);
   localparam int TW = $clog2(REPEAT_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(REPEAT_TIMEOUT);
   localparam logic [KEY_WIDTH-1:0] LAST = KEY_WIDTH'(NUM_KEYS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] EMIT   = 2'd2;

   logic [1:0]              state;
   logic [SIGNAL_WIDTH-1:0] code;
   logic [KEY_WIDTH-1:0]    idx;
   logic [KEY_WIDTH-1:0]    key;
   logic                    key_repeat;
   logic                    held;
   logic                    unknown;
   logic                    overrun;
   logic [TW-1:0]           timer;
   logic [SIGNAL_WIDTH-1:0] tbl_code [NUM_KEYS];
   logic [NUM_KEYS-1:0]     tbl_valid;
   logic                    hit;
   logic                    busy;
   logic                    reload;

   function automatic logic [SIGNAL_WIDTH-1:0] default_code(input int i);
      logic [31:0] c;
      case (i)
         0:       c = 32'hA857D02F;
         1:       c = 32'hA857807F;
         2:       c = 32'hA85740BF;
         3:       c = 32'hA857C03F;
         4:       c = 32'hA85720DF;
         5:       c = 32'hA857A05F;
         6:       c = 32'hA857609F;
         7:       c = 32'hA857E01F;
         8:       c = 32'hA85710EF;
         9:       c = 32'hA857906F;
         default: c = 32'h0;
      endcase
      return SIGNAL_WIDTH'(c);
   endfunction

   assign hit  = tbl_valid[idx] && (tbl_code[idx] == code);
   assign busy = (state != IDLE);
   // A repeat arriving alongside a new code in IDLE is dropped outright
   assign reload = held && bus.i_repeat &&
                   !(!busy && bus.i_code_valid);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         code       <= '0;
         idx        <= '0;
         key        <= '1;
         key_repeat <= 1'b0;
         held       <= 1'b0;
         unknown    <= 1'b0;
         overrun    <= 1'b0;
         timer      <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            tbl_code[i]  <= default_code(i);
            tbl_valid[i] <= (i < 10);
         end
      end else begin
         unknown <= 1'b0;
         overrun <= busy && (bus.i_code_valid || bus.i_repeat);

         if (bus.i_tbl_we) begin
            tbl_code[bus.i_tbl_addr]  <= bus.i_tbl_code;
            tbl_valid[bus.i_tbl_addr] <= 1'b1;
         end

         if (held) begin
            if (reload) begin
               timer <= T_LOAD;
            end else if (timer <= TW'(1)) begin
               timer <= '0;
               held  <= 1'b0;
            end else begin
               timer <= timer - 1'b1;
            end
         end

         unique case (state)
            IDLE: begin
               if (bus.i_code_valid) begin
                  code  <= bus.i_code;
                  idx   <= '0;
                  state <= SEARCH;
               end else if (bus.i_repeat && held) begin
                  key_repeat <= 1'b1;
                  state      <= EMIT;
               end
            end
            SEARCH: begin
               if (hit) begin
                  key        <= idx;
                  key_repeat <= 1'b0;
                  held       <= 1'b1;
                  timer      <= T_LOAD;
                  state      <= EMIT;
               end else if (idx == LAST) begin
                  unknown <= 1'b1;
                  held    <= 1'b0;
                  timer   <= '0;
                  state   <= IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            EMIT: begin
               if (bus.i_key_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_key        = key;
   assign bus.o_key_repeat = key_repeat;
   assign bus.o_key_valid  = (state == EMIT);
   assign bus.o_held       = held;
   assign bus.o_unknown    = unknown;
   assign bus.o_overrun    = overrun;
endmodule

// File: doc/ir_key_event_decoder.md
# ir_key_event_decoder

Sequential, table-driven successor to the fixed digit decoder. Takes each captured IR frame code (plus the receiver's NEC repeat-frame strobe) and searches a run-time programmable table of NUM_KEYS codes. Produces key-press and auto-repeat events on a valid/ready port and tracks key hold/release with a repeat timeout. Sits between the IR frame receiver and the remote-control command logic.

## Interface
- SIGNAL_WIDTH, 32, width of a frame code
- NUM_KEYS, 16, number of table entries (2..256)
- KEY_WIDTH, $clog2(NUM_KEYS), width of key index
- REPEAT_TIMEOUT, 6_000_000, cycles without a repeat frame before release (120 ms at 50 MHz)

- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_code  in  SIGNAL_WIDTH  frame code, qualified by i_code_valid
- i_code_valid  in  1  one-cycle strobe: new frame received
- i_repeat  in  1  one-cycle strobe: NEC repeat frame received
- i_tbl_we  in  1  table write enable
- i_tbl_addr  in  KEY_WIDTH  table write index
- i_tbl_code  in  SIGNAL_WIDTH  table write data (sets entry valid)
- o_key  out  KEY_WIDTH  key index of current event
- o_key_repeat  out  1  event is an auto-repeat
- o_key_valid  out  1  event available
- i_key_ready  in  1  consumer accepts event
- o_held  out  1  level: a key is currently held
- o_unknown  out  1  one-cycle pulse: code matched no entry
- o_overrun  out  1  one-cycle pulse: strobe discarded while busy

## Operation
- Table: NUM_KEYS entries of {valid, code}. Reset loads entries 0..9 with A857D02F, A857807F, A85740BF, A857C03F, A85720DF, A857A05F, A857609F, A857E01F, A85710EF, A857906F (hex), valid=1. Other entries are code 0, valid=0. Entries beyond index NUM_KEYS-1 of this list are dropped.
- i_tbl_we writes any cycle and sets valid=1. A comparison in the same cycle on the same entry uses the old value.
- FSM states: IDLE, SEARCH, EMIT.
  - IDLE + i_code_valid: latch i_code, index←0, go to SEARCH.
  - SEARCH: compare one entry per cycle, ascending index; a valid entry with code equal to the latched code matches. The lowest matching index wins.
  - On match at j: o_key←j, o_key_repeat←0, held←1, load timer, go to EMIT.
  - No match after entry NUM_KEYS-1: pulse o_unknown, held←0, go to IDLE.
  - EMIT: o_key_valid=1, with o_key/o_key_repeat stable, until i_key_ready=1. Return to IDLE on the next cycle.
- Repeat: IDLE + i_repeat with held=1: reload timer, o_key_repeat←1, go to EMIT with the last key. IDLE + i_repeat with held=0: ignored, no pulse.
- Hold timer: width $clog2(REPEAT_TIMEOUT+1). Decrements every cycle while held=1 in any state. Reaching 0 clears held.
- Busy handling (SEARCH or EMIT):
  - i_code_valid: discarded, pulse o_overrun.
  - i_repeat: reloads the timer if held=1, emits no event, pulses o_overrun.
- Simultaneous events:
  - i_code_valid with i_repeat in IDLE: the code wins; the repeat is dropped silently.
  - Timer expiry with a repeat strobe in the same cycle: the repeat wins (reload, held stays 1).
- Reset mid-operation: any pending event is lost; all state returns to reset values on the next edge.

## Timing
- Reset values: FSM=IDLE, o_key=all ones, o_key_repeat=0, o_key_valid=0, o_held=0, o_unknown=0, o_overrun=0, timer=0.
- Latency, i_code_valid sampled at edge 0:
  - Entry j is compared in cycle j+1.
  - Match at j: o_key_valid is high from cycle j+2.
  - No match: o_unknown pulses in cycle NUM_KEYS+1, and IDLE accepts a new code in that same cycle.
- Repeat latency: i_repeat sampled at edge 0 gives o_key_valid in cycle 1.
- Handshake: transfer occurs in the cycle where o_key_valid and i_key_ready are both high. o_key_valid is low the next cycle. New strobes are accepted from that cycle. No combinational ready→valid path.
- o_held is registered and equals the held flag.

## Test plan
- Reset defaults: code A857D02F at cycle 0 → o_key_valid in cycle 2, o_key=0, o_key_repeat=0, o_held=1. Code A857906F → o_key=9 in cycle 11.
- Unknown and table write: code 12345678 → o_unknown pulse in cycle 17 (NUM_KEYS=16), no event, o_held=0. Then write entry 12=12345678 and resend → o_key=12 in cycle 14.
- Back-pressure and overrun: hold i_key_ready=0 for 20 cycles after a match → o_key/o_key_valid stable. A code strobe during the wait → o_overrun pulse, no second event.
- Repeat and release (REPEAT_TIMEOUT=100): match key 5, then i_repeat every 80 cycles ×3 → three events, o_key=5, o_key_repeat=1. With no further repeat, o_held falls 100 cycles after the last repeat; a later i_repeat produces no event.
- Simultaneity:
  - i_code_valid+i_repeat together in IDLE → only the code event.
  - Repeat on the expiry cycle → o_held stays 1.
  - Table write to the entry under comparison → old value is used.
- Reset asserted during SEARCH and again during EMIT → all outputs at reset values next cycle, no event.
